// File: rtl/weight_buffer_pp.sv
// -----------------------------------------------------------------------------
// weight_buffer_pp
// Ping-pong weight store between the weight DMA write channel and the
// convolution weight fetch port. The DMA fills one bank while the convolution
// engine reads the other; banks are handed over with explicit fill (w_last)
// and consume (conv_en / w_done) handshakes.
//
// Optional feature macro: WBUF_OUT_REG_EN
//   defined   -> extra output register on rd_data/rd_data_vld (2-cycle read)
//   undefined -> 1-cycle read latency
//
// Ports
//   clk, rstn          : clock (rising edge), synchronous active-low reset
//   enable             : block enable; low blocks writes and all consumer inputs
//   w_addr/w_data      : DMA write address (within fill bank) and data
//   w_valid/w_ready    : DMA write handshake; w_last closes the bank fill
//   conv_en            : consumer claims the next FULL bank
//   w_done             : consumer releases the bank it is reading
//   rd_addr/rd_vld     : read request into the READING bank
//   rd_data/rd_data_vld: read data and its valid strobe
//   bank_full          : per-bank FULL-or-READING status
//   wt_avail           : bank at the read pointer is FULL
//   err                : sticky protocol-error flag
// -----------------------------------------------------------------------------
module weight_buffer_pp #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int ADDR_SIZE  = 10
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  enable,
   input  logic [ADDR_SIZE-1:0]  w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  w_valid,
   input  logic                  w_last,
   output logic                  w_ready,
   input  logic                  conv_en,
   input  logic                  w_done,
   input  logic [ADDR_SIZE-1:0]  rd_addr,
   input  logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_vld,
   output logic [1:0]            bank_full,
   output logic                  wt_avail,
   output logic                  err
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2,
      ST_READING = 2'd3
   } bank_st_t;

   localparam int                 IDX_W   = $clog2(2 * DEPTH);
   localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE + 1)'(DEPTH);

   // Flat RAM index: bank 1 occupies the upper DEPTH words.
   function automatic logic [IDX_W-1:0] f_idx(input logic sel, input logic [ADDR_SIZE-1:0] addr);
      return (sel ? IDX_W'(DEPTH) : {IDX_W{1'b0}}) + IDX_W'(addr);
   endfunction

   function automatic logic f_holds_data(input bank_st_t st);
      return (st == ST_FULL) || (st == ST_READING);
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [0:2*DEPTH-1];

   bank_st_t r_state [2];
   bank_st_t w_state_nxt [2];
   logic     r_wr_sel;
   logic     r_rd_sel;
   logic     w_wr_sel_nxt;
   logic     w_rd_sel_nxt;
   logic     r_err;
   logic [1:0] r_bank_full;
   logic     r_wt_avail;

   bank_st_t w_wr_st;
   bank_st_t w_rd_st;
   logic     w_ready_s;
   logic     w_wr_hs;
   logic     w_wr_in_rng;
   logic     w_wr_store;
   logic     w_rd_in_rng;
   logic     w_rd_ok;
   logic     w_done_ok;
   logic     w_conv_ok;
   logic     w_err_evt;
   logic [IDX_W-1:0] w_wr_idx;
   logic [IDX_W-1:0] w_rd_idx;

   logic [DATA_WIDTH-1:0] r_rd_data1;
   logic                  r_rd_vld1;

   assign w_wr_st = r_state[r_wr_sel];
   assign w_rd_st = r_state[r_rd_sel];

   // rstn gates w_ready so the DMA never sees a handshake while reset is held.
   assign w_ready_s = rstn & enable & ((w_wr_st == ST_EMPTY) | (w_wr_st == ST_FILLING));
   assign w_ready   = w_ready_s;

   assign w_wr_hs     = w_valid & w_ready_s;
   assign w_wr_in_rng = ({1'b0, w_addr} < DEPTH_C);
   assign w_wr_store  = w_wr_hs & w_wr_in_rng;
   assign w_wr_idx    = f_idx(r_wr_sel, w_addr);

   assign w_rd_in_rng = ({1'b0, rd_addr} < DEPTH_C);
   assign w_rd_ok     = enable & rd_vld & (w_rd_st == ST_READING) & w_rd_in_rng;
   assign w_rd_idx    = f_idx(r_rd_sel, rd_addr);

   // w_done wins over a simultaneous conv_en; the conv_en is then an error.
   assign w_done_ok = enable & w_done & (w_rd_st == ST_READING);
   assign w_conv_ok = enable & conv_en & ~w_done & (w_rd_st == ST_FULL);

   assign w_err_evt = (w_wr_hs & ~w_wr_in_rng)
                    | (enable & rd_vld & ~w_rd_ok)
                    | (enable & conv_en & (w_done | (w_rd_st != ST_FULL)))
                    | (enable & w_done & (w_rd_st != ST_READING));

   // Next bank states and pointers. The fill bank is EMPTY/FILLING while the
   // read-side events need FULL/READING, so both sides never hit one bank.
   always_comb begin
      w_state_nxt[0] = r_state[0];
      w_state_nxt[1] = r_state[1];
      w_wr_sel_nxt   = r_wr_sel;
      w_rd_sel_nxt   = r_rd_sel;
      if (w_wr_hs) begin
         if (w_last) begin
            w_state_nxt[r_wr_sel] = ST_FULL;
            w_wr_sel_nxt          = ~r_wr_sel;
         end else begin
            w_state_nxt[r_wr_sel] = ST_FILLING;
         end
      end else begin
         w_wr_sel_nxt = r_wr_sel;
      end
      if (w_done_ok) begin
         w_state_nxt[r_rd_sel] = ST_EMPTY;
         w_rd_sel_nxt          = ~r_rd_sel;
      end else if (w_conv_ok) begin
         w_state_nxt[r_rd_sel] = ST_READING;
      end else begin
         w_rd_sel_nxt = r_rd_sel;
      end
   end

   // Bank FSMs, pointers and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state[0]  <= ST_EMPTY;
         r_state[1]  <= ST_EMPTY;
         r_wr_sel    <= 1'b0;
         r_rd_sel    <= 1'b0;
         r_err       <= 1'b0;
         r_bank_full <= 2'b00;
         r_wt_avail  <= 1'b0;
      end else begin
         r_state[0]  <= w_state_nxt[0];
         r_state[1]  <= w_state_nxt[1];
         r_wr_sel    <= w_wr_sel_nxt;
         r_rd_sel    <= w_rd_sel_nxt;
         r_err       <= r_err | w_err_evt;
         r_bank_full <= {f_holds_data(w_state_nxt[1]), f_holds_data(w_state_nxt[0])};
         r_wt_avail  <= (w_state_nxt[w_rd_sel_nxt] == ST_FULL);
      end
   end

   // RAM write port; contents are deliberately left intact across reset.
   always_ff @(posedge clk) begin
      if (w_wr_store) begin
         r_mem[w_wr_idx] <= w_data;
      end
   end

   // First read stage; data holds its last value when no read is accepted.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rd_data1 <= {DATA_WIDTH{1'b0}};
         r_rd_vld1  <= 1'b0;
      end else begin
         r_rd_vld1 <= w_rd_ok;
         if (w_rd_ok) begin
            r_rd_data1 <= r_mem[w_rd_idx];
         end
      end
   end

`ifdef WBUF_OUT_REG_EN
   logic [DATA_WIDTH-1:0] r_rd_data2;
   logic                  r_rd_vld2;

   // Second output stage; loads only on valid data so rd_data still holds.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rd_data2 <= {DATA_WIDTH{1'b0}};
         r_rd_vld2  <= 1'b0;
      end else begin
         r_rd_vld2 <= r_rd_vld1;
         if (r_rd_vld1) begin
            r_rd_data2 <= r_rd_data1;
         end
      end
   end

   assign rd_data     = r_rd_data2;
   assign rd_data_vld = r_rd_vld2;
`else
   assign rd_data     = r_rd_data1;
   assign rd_data_vld = r_rd_vld1;
`endif

   assign bank_full = r_bank_full;
   assign wt_avail  = r_wt_avail;
   assign err       = r_err;

endmodule

// File: tb/tb_weight_buffer_pp.sv
// Bench for weight_buffer_pp: directed table, hand sequences for reset
// corner cases, then random traffic against a bank-level reference model.
module tb_weight_buffer_pp;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int AS    = 5;
`ifdef WBUF_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rstn, enable, w_valid, w_last, w_ready, conv_en, w_done, rd_vld;
   logic [AS-1:0] w_addr, rd_addr;
   logic [DW-1:0] w_data, rd_data;
   logic          rd_data_vld, wt_avail, err;
   logic [1:0]    bank_full;

   always #5 clk = ~clk;

   weight_buffer_pp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_SIZE(AS)) dut (
      .clk(clk), .rstn(rstn), .enable(enable),
      .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_last(w_last),
      .w_ready(w_ready), .conv_en(conv_en), .w_done(w_done),
      .rd_addr(rd_addr), .rd_vld(rd_vld), .rd_data(rd_data),
      .rd_data_vld(rd_data_vld), .bank_full(bank_full),
      .wt_avail(wt_avail), .err(err)
   );

   // ---------------- reference model ----------------
   typedef enum int {M_EMPTY, M_FILLING, M_FULL, M_READING} mst_t;
   mst_t          m_st [2];
   int            m_wsel, m_rsel;
   bit            m_err;
   logic [DW-1:0] m_mem [2][DEPTH];
   bit            m_known [2][DEPTH];
   bit            p_v [LAT];
   logic [DW-1:0] p_d [LAT];
   bit            p_k [LAT];
   bit            e_vld, e_known;
   logic [DW-1:0] e_dat;

   int n_chk = 0;
   int n_err = 0;

   function automatic bit model_ready();
      return rstn && enable && (m_st[m_wsel] == M_EMPTY || m_st[m_wsel] == M_FILLING);
   endfunction

   function automatic bit [1:0] model_bf();
      bit [1:0] r;
      for (int b = 0; b < 2; b++) r[b] = (m_st[b] == M_FULL) || (m_st[b] == M_READING);
      return r;
   endfunction

   function automatic void model_reset();
      m_st[0] = M_EMPTY; m_st[1] = M_EMPTY;
      m_wsel = 0; m_rsel = 0; m_err = 1'b0;
      for (int k = 0; k < LAT; k++) begin p_v[k] = 1'b0; p_d[k] = '0; p_k[k] = 1'b1; end
      e_vld = 1'b0; e_dat = '0; e_known = 1'b1;
   endfunction

   // Applies the buffer rules for one clock edge, using pre-edge state.
   function automatic void model_edge();
      mst_t          old_st [2];
      int            ow, orr;
      bit            nv, nk, rdy;
      logic [DW-1:0] nd;
      if (!rstn) begin
         model_reset();
         return;
      end
      old_st = m_st; ow = m_wsel; orr = m_rsel;
      rdy = model_ready();
      nv = 1'b0; nd = '0; nk = 1'b1;
      if (enable && rd_vld) begin
         if (old_st[orr] == M_READING && int'(rd_addr) < DEPTH) begin
            nv = 1'b1; nd = m_mem[orr][rd_addr]; nk = m_known[orr][rd_addr];
         end else m_err = 1'b1;
      end
      if (enable && w_done) begin
         if (conv_en) m_err = 1'b1;
         if (old_st[orr] == M_READING) begin m_st[orr] = M_EMPTY; m_rsel = 1 - orr; end
         else m_err = 1'b1;
      end else if (enable && conv_en) begin
         if (old_st[orr] == M_FULL) m_st[orr] = M_READING;
         else m_err = 1'b1;
      end
      if (w_valid && rdy) begin
         if (int'(w_addr) < DEPTH) begin
            m_mem[ow][w_addr] = w_data; m_known[ow][w_addr] = 1'b1;
         end else m_err = 1'b1;
         if (w_last) begin m_st[ow] = M_FULL; m_wsel = 1 - ow; end
         else m_st[ow] = M_FILLING;
      end
      for (int k = LAT - 1; k > 0; k--) begin p_v[k] = p_v[k-1]; p_d[k] = p_d[k-1]; p_k[k] = p_k[k-1]; end
      p_v[0] = nv; p_d[0] = nd; p_k[0] = nk;
      if (p_v[LAT-1]) begin e_vld = 1'b1; e_dat = p_d[LAT-1]; e_known = p_k[LAT-1]; end
      else e_vld = 1'b0;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   typedef struct {
      bit            rs, en, wv;
      logic [AS-1:0] wa;
      logic [DW-1:0] wd;
      bit            wl, ce, dn, rv;
      logic [AS-1:0] ra;
      bit            er;   // expected w_ready before the edge
      bit [1:0]      bf;   // expected bank_full after the edge
      bit            av, ee;
   } vec_t;

   function automatic vec_t mkv(input bit rs, en, wv, input int wa, input logic [DW-1:0] wd,
                                input bit wl, ce, dn, rv, input int ra,
                                input bit er, input bit [1:0] bf, input bit av, ee);
      vec_t v;
      v.rs = rs; v.en = en; v.wv = wv; v.wa = AS'(wa); v.wd = wd; v.wl = wl;
      v.ce = ce; v.dn = dn; v.rv = rv; v.ra = AS'(ra);
      v.er = er; v.bf = bf; v.av = av; v.ee = ee;
      return v;
   endfunction

   // One clock: drive, check w_ready, clock, check registered outputs.
   task automatic cycle(input vec_t v, input bit use_tbl);
      rstn = v.rs; enable = v.en; w_valid = v.wv; w_addr = v.wa; w_data = v.wd;
      w_last = v.wl; conv_en = v.ce; w_done = v.dn; rd_vld = v.rv; rd_addr = v.ra;
      #1;
      chk("w_ready", 32'(w_ready), 32'(model_ready()));
      if (use_tbl) chk("tbl_w_ready", 32'(w_ready), 32'(v.er));
      @(posedge clk);
      model_edge();
      #1;
      chk("rd_data_vld", 32'(rd_data_vld), 32'(e_vld));
      if (e_known) chk("rd_data", rd_data, e_dat);
      chk("bank_full", 32'(bank_full), 32'(model_bf()));
      chk("wt_avail", 32'(wt_avail), 32'(m_st[m_rsel] == M_FULL));
      chk("err", 32'(err), 32'(m_err));
      if (use_tbl) begin
         chk("tbl_bank_full", 32'(bank_full), 32'(v.bf));
         chk("tbl_wt_avail", 32'(wt_avail), 32'(v.av));
         chk("tbl_err", 32'(err), 32'(v.ee));
      end
   endtask

   vec_t tbl[$];

   initial begin
      model_reset();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < DEPTH; a++) begin m_mem[b][a] = '0; m_known[b][a] = 1'b0; end
      rstn = 1'b0; enable = 1'b0; w_valid = 1'b0; w_last = 1'b0; conv_en = 1'b0;
      w_done = 1'b0; rd_vld = 1'b0; w_addr = '0; rd_addr = '0; w_data = '0;

      // ---- directed table ----
      //                 rs en wv wa  wd          wl ce dn rv ra  rdy bf     av ee
      tbl.push_back(mkv(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0,  0, 2'b00, 0, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  1, 2'b00, 0, 0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mkv(1, 1, 1, k, 32'hA0 + k, k == 3, 0, 0, 0, 0, 1, (k == 3) ? 2'b01 : 2'b00, k == 3, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 1, 0, 0, 0,  1, 2'b01, 0, 0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mkv(1, 1, 1, k, 32'hB0 + k, k == 3, 0, 0, 1, k, 1, (k == 3) ? 2'b11 : 2'b01, 0, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  0, 2'b11, 0, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 1, 0, 0,  0, 2'b10, 1, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  1, 2'b10, 1, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 1, 0, 0, 0,  1, 2'b10, 0, 0));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mkv(1, 1, 0, 0, 32'h0,     0, 0, 0, 1, k,  1, 2'b10, 0, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 1, 0, 0,  1, 2'b00, 0, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  1, 2'b00, 0, 0));
      // protocol errors, each isolated by a reset
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0,  1, 2'b00, 0, 1));
      tbl.push_back(mkv(0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  0, 2'b00, 0, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 1, 0, 0, 0,  1, 2'b00, 0, 1));
      tbl.push_back(mkv(0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  0, 2'b00, 0, 0));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 1, 0, 0,  1, 2'b00, 0, 1));
      tbl.push_back(mkv(0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  0, 2'b00, 0, 0));
      // out-of-range write still completes the fill; enable=0 ignores conv_en
      tbl.push_back(mkv(1, 1, 1, DEPTH, 32'hDEAD, 1, 0, 0, 0, 0,  1, 2'b01, 1, 1));
      tbl.push_back(mkv(1, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0,  0, 2'b01, 1, 1));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 1, 0, 0, 0,  1, 2'b01, 0, 1));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0,  1, 2'b01, 0, 1));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 1, 0, 0,  1, 2'b00, 0, 1));
      tbl.push_back(mkv(1, 1, 1, 1, 32'hC1,       1, 0, 0, 0, 0,  1, 2'b10, 1, 1));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 1, 0, 0, 0,  1, 2'b10, 0, 1));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 0,  1, 2'b10, 0, 1));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 1, 0, 0,  1, 2'b00, 0, 1));
      tbl.push_back(mkv(1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0,  1, 2'b00, 0, 1));
      foreach (tbl[i]) cycle(tbl[i], 1'b1);

      // ---- reset mid-fill, then refill lands in bank 0 ----
      cycle(mkv(0, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b1);
      cycle(mkv(1, 1, 1, 0, 32'h11, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), 1'b1);
      cycle(mkv(1, 1, 1, 1, 32'h12, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), 1'b1);
      cycle(mkv(0, 1, 1, 2, 32'h13, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b1);
      chk("rst_fill_vld", 32'(rd_data_vld), 32'h0);
      chk("rst_fill_data", rd_data, 32'h0);
      cycle(mkv(1, 1, 1, 0, 32'h21, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0), 1'b1);
      cycle(mkv(1, 1, 1, 1, 32'h22, 1, 0, 0, 0, 0, 1, 2'b01, 1, 0), 1'b1);
      cycle(mkv(1, 1, 0, 0, 32'h0,  0, 1, 0, 0, 0, 1, 2'b01, 0, 0), 1'b1);
      // single read, checked at its documented latency
      cycle(mkv(1, 1, 0, 0, 32'h0,  0, 0, 0, 1, 1, 1, 2'b01, 0, 0), 1'b1);
      for (int k = 1; k < LAT; k++) begin
         chk("lat_early_vld", 32'(rd_data_vld), 32'h0);
         cycle(mkv(1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0), 1'b1);
      end
      chk("lat_vld", 32'(rd_data_vld), 32'h1);
      chk("lat_data", rd_data, 32'h22);
      // ---- reset mid-read ----
      cycle(mkv(1, 1, 0, 0, 32'h0,  0, 0, 0, 1, 0, 1, 2'b01, 0, 0), 1'b1);
      cycle(mkv(0, 1, 0, 0, 32'h0,  0, 0, 0, 1, 1, 0, 2'b00, 0, 0), 1'b1);
      chk("rst_rd_vld", 32'(rd_data_vld), 32'h0);
      chk("rst_rd_data", rd_data, 32'h0);
      cycle(mkv(1, 1, 1, 0, 32'h31, 1, 0, 0, 0, 0, 1, 2'b01, 1, 0), 1'b1);
      cycle(mkv(1, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 2'b01, 1, 0), 1'b1);

      // ---- random traffic against the model ----
      for (int n = 0; n < 1500; n++) begin
         vec_t v;
         v = mkv($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, DEPTH), $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, DEPTH), 1'b0, 2'b00, 1'b0, 1'b0);
         cycle(v, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
